// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time IMEM loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        WRITE,
        DONE,
        ERROR
    } state_t;

    localparam int unsigned HDR_BYTES  = 2;
    localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and IMEM write port of the loader; slave is the loader side.
interface imem_loader_if;

    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    modport slave (
        input  byte_data, byte_valid,
        output byte_ready, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output byte_data, byte_valid,
        input  byte_ready, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// Packs big-endian stream bytes into a 32-bit word; flags the accept that completes it.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        nrst,
    input  logic        i_clear,
    input  logic        i_accept,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_full
);

    logic [1:0]  r_cnt;
    logic [31:0] r_shift;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (i_clear) begin
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (i_accept) begin
            r_cnt   <= r_cnt + 2'd1;
            r_shift <= {r_shift[23:0], i_byte};
        end
    end

    assign o_word_full = i_accept && (r_cnt == 2'(WORD_BYTES - 1));
    assign o_word      = r_shift;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a 16-bit word-count header, writes packed words to IMEM,
// and holds the core in reset until the image is complete.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                clk,
    input  logic                nrst,
    imem_loader_if.slave        bus,
    input  logic                start,
    output logic                cpu_nrst,
    output logic [ADDR_WIDTH:0] words_loaded,
    output logic                error
);

    localparam logic [16:0] CAPACITY = 17'(1) << ADDR_WIDTH;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [15:0]         r_len;
    logic [ADDR_WIDTH:0] r_words;
    logic [31:0]         r_mem_addr;
    logic [31:0]         r_mem_wdata;

    logic                w_byte_ready;
    logic                w_accept;
    logic                w_data_accept;
    logic                w_clear;
    logic                w_word_full;
    logic [31:0]         w_word;
    logic [31:0]         w_wr_addr;
    logic [15:0]         w_len;
    logic [ADDR_WIDTH:0] w_words_inc;

    assign w_byte_ready  = (r_state == LEN_HI) || (r_state == LEN_LO) || (r_state == DATA);
    assign w_accept      = w_byte_ready && bus.byte_valid;
    assign w_data_accept = w_accept && (r_state == DATA);
    assign w_len         = {r_len[15:8], bus.byte_data};
    assign w_words_inc   = r_words + {{ADDR_WIDTH{1'b0}}, 1'b1};
    assign w_wr_addr     = 32'(r_words) << 2;

    byte_packer u_packer (
        .clk         (clk),
        .nrst        (nrst),
        .i_clear     (w_clear),
        .i_accept    (w_data_accept),
        .i_byte      (bus.byte_data),
        .o_word      (w_word),
        .o_word_full (w_word_full)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        case (r_state)
            IDLE: begin
                w_state_nxt = LEN_HI;
                w_clear     = 1'b1;
            end
            LEN_HI: if (w_accept) w_state_nxt = LEN_LO;
            LEN_LO: begin
                if (w_accept) begin
                    if (w_len == 16'd0)                 w_state_nxt = DONE;
                    else if ({1'b0, w_len} > CAPACITY)  w_state_nxt = ERROR;
                    else                                w_state_nxt = DATA;
                end
            end
            DATA: if (w_word_full) w_state_nxt = WRITE;
            WRITE: begin
                if (16'(w_words_inc) == r_len) w_state_nxt = DONE;
                else                           w_state_nxt = DATA;
            end
            DONE, ERROR: begin
                if (start) begin
                    w_state_nxt = LEN_HI;
                    w_clear     = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_len       <= '0;
            r_words     <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            if (w_accept && (r_state == LEN_HI)) r_len[15:8] <= bus.byte_data;
            if (w_accept && (r_state == LEN_LO)) r_len[7:0]  <= bus.byte_data;
            if (w_clear)                 r_words <= '0;
            else if (r_state == WRITE)   r_words <= w_words_inc;
            if (r_state == WRITE) begin
                r_mem_addr  <= w_wr_addr;
                r_mem_wdata <= w_word;
            end
        end
    end

    // Live values during WRITE, captured copies afterwards so the bus holds the last write.
    assign bus.mem_we     = (r_state == WRITE);
    assign bus.mem_addr   = (r_state == WRITE) ? w_wr_addr : r_mem_addr;
    assign bus.mem_wdata  = (r_state == WRITE) ? w_word    : r_mem_wdata;
    assign bus.byte_ready = w_byte_ready;
    assign cpu_nrst       = (r_state == DONE);
    assign error          = (r_state == ERROR);
    assign words_loaded   = r_words;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected writes go to a queue, a negedge monitor checks them.
module tb_imem_loader;

    logic       clk = 1'b0;
    logic       nrst;
    logic       start;
    logic       cpu_nrst;
    logic       error;
    logic [8:0] words_loaded;

    imem_loader_if bus();

    imem_loader #(.ADDR_WIDTH(8)) dut (
        .clk          (clk),
        .nrst         (nrst),
        .bus          (bus),
        .start        (start),
        .cpu_nrst     (cpu_nrst),
        .words_loaded (words_loaded),
        .error        (error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] img[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned n_we    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        wr_t e;
        if (nrst === 1'b1 && bus.mem_we === 1'b1) begin
            n_we++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_we: addr 0x%08h data 0x%08h, expected no write",
                         bus.mem_addr, bus.mem_wdata);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", bus.mem_addr, e.addr);
                check("wr_data", bus.mem_wdata, e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int unsigned w = 0;
        bus.byte_data  = b;
        bus.byte_valid = 1'b1;
        while (bus.byte_ready !== 1'b1 && w < 50) begin
            tick();
            w++;
        end
        if (bus.byte_ready !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL ready_timeout: byte_ready=%b after 50 cycles, expected 1", bus.byte_ready);
        end
        tick();
        bus.byte_valid = 1'b0;
    endtask

    task automatic gap();
        check("gap_ready", 32'(bus.byte_ready), 32'd1);
        tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic load_image(input logic [15:0] n, input logic throttle, input logic start_at_last);
        logic [31:0] wd;
        int unsigned we_before = n_we;
        send_byte(n[15:8]);
        if (throttle) gap();
        send_byte(n[7:0]);
        for (int i = 0; i < int'(n); i++) begin
            wd = img[i];
            exp_q.push_back({32'(i) << 2, wd});
            for (int k = 0; k < 4; k++) begin
                send_byte(wd[31 - 8*k -: 8]);
                if (throttle && k < 3) gap();
            end
        end
        if (n != 16'd0) begin
            check("we_in_write", 32'(bus.mem_we), 32'd1);
            check("cpu_nrst_in_write", 32'(cpu_nrst), 32'd0);
            if (start_at_last) start = 1'b1;
            tick();
            start = 1'b0;
            check("cpu_nrst_rise", 32'(cpu_nrst), 32'd1);
            check("words_loaded", 32'(words_loaded), 32'(n));
            check("sb_drained", 32'(exp_q.size()), 32'd0);
            if (start_at_last) begin
                tick();
                check("start_ignored", 32'(cpu_nrst), 32'd1);
            end
        end else begin
            tick();
            check("empty_done", 32'(cpu_nrst), 32'd1);
            check("empty_no_we", n_we - we_before, 32'd0);
            check("empty_count", 32'(words_loaded), 32'd0);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_byte_ready"}, 32'(bus.byte_ready), 32'd0);
        check({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
        check({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
        check({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
        check({tag, "_cpu_nrst"}, 32'(cpu_nrst), 32'd0);
        check({tag, "_words"}, 32'(words_loaded), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        nrst           = 1'b1;
        start          = 1'b0;
        bus.byte_data  = 8'h00;
        bus.byte_valid = 1'b0;
        #1 nrst = 1'b0;
        #2 check_reset_values("reset");
        tick();
        tick();
        nrst = 1'b1;

        // Basic load
        img = '{32'h20080005, 32'hAC080000};
        load_image(16'd2, 1'b0, 1'b0);

        // Reload from DONE, throttled stream, start during the final WRITE
        pulse_start();
        check("reload_cpu_nrst", 32'(cpu_nrst), 32'd0);
        check("reload_words", 32'(words_loaded), 32'd0);
        check("reload_ready", 32'(bus.byte_ready), 32'd1);
        load_image(16'd2, 1'b1, 1'b1);

        // Empty image
        pulse_start();
        load_image(16'd0, 1'b0, 1'b0);

        // Overflow header, then recovery with a full-capacity image
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h01);
        check("ovf_error", 32'(error), 32'd1);
        check("ovf_ready", 32'(bus.byte_ready), 32'd0);
        check("ovf_cpu_nrst", 32'(cpu_nrst), 32'd0);
        tick();
        check("ovf_sticky", 32'(error), 32'd1);
        check("ovf_cpu_nrst_hold", 32'(cpu_nrst), 32'd0);
        pulse_start();
        check("ovf_error_clear", 32'(error), 32'd0);
        img.delete();
        for (int i = 0; i < 256; i++) img.push_back(32'hA5000000 | (32'(i) * 32'h00010101));
        load_image(16'd256, 1'b0, 1'b0);
        check("full_last_addr", bus.mem_addr, 32'h000003FC);

        // Asynchronous reset after two data bytes
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'hDE);
        send_byte(8'hAD);
        nrst = 1'b0;
        #1 check_reset_values("midreset");
        tick();
        nrst = 1'b1;
        img = '{32'h12345678};
        load_image(16'd1, 1'b0, 1'b0);
        check("midreset_addr", bus.mem_addr, 32'h00000000);

        tick();
        check("final_sb_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
